// File: rtl/led_pattern_pkg.sv
// Shared mode encoding and helpers for the LED pattern generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_GRAY    = 2'd1,
    MODE_SCAN    = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  // Reflected binary code. The argument is 32 bits wide so that callers of
  // any width up to 32 can use it; zero-extended inputs give zero-extended
  // results.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Free-running prescaler producing the pattern-step and breath-step strobes.
// Latency: strobes are combinational from the prescaler; first step is seen
// in cycle 2**LOG2DELAY-1 after reset. Backpressure: pause freezes the count.
module led_tick_gen #(
  parameter int LOG2DELAY   = 22,
  parameter int BREATH_LOG2 = 14,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                pause,
  output logic                step,
  output logic                breath_step,
  output logic [PWM_BITS-1:0] pwm_phase_nxt
);

  logic [LOG2DELAY-1:0] prescaler;

  // Prescaler counts every unpaused cycle and wraps naturally.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prescaler <= '0;
    end else if (!pause) begin
      prescaler <= prescaler + LOG2DELAY'(1);
    end
  end

  // A paused cycle never produces a strobe, even on the terminal count.
  assign step        = (&prescaler) & ~pause;
  assign breath_step = (&prescaler[BREATH_LOG2-1:0]) & ~pause;

  // PWM compare uses the prescaler value that will be live once the LED
  // register has loaded, so the pin and the counter stay in phase.
  assign pwm_phase_nxt = prescaler[PWM_BITS-1:0] + PWM_BITS'(1);

endmodule

// File: rtl/led_pattern_gen.sv
// Steps a run-time-selected LED pattern (binary, Gray, scanner, breathing).
// Latency: leds and tick are registered and update on the same edge, one
// cycle after the step strobe. Backpressure: pause holds all state and leds.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS    = 5,
  parameter int LOG2DELAY   = 22,
  parameter int BREATH_LOG2 = 14,
  parameter int PWM_BITS    = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          mode,
  input  logic                pause,
  output logic [NUM_LEDS-1:0] leds,
  output logic                tick
);

  localparam int                POS_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0]  POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] BRIGHT_MAX = '1;

  logic                step;
  logic                breath_step;
  logic [PWM_BITS-1:0] pwm_phase_nxt;

  led_tick_gen #(
    .LOG2DELAY   (LOG2DELAY),
    .BREATH_LOG2 (BREATH_LOG2),
    .PWM_BITS    (PWM_BITS)
  ) u_tick_gen (
    .clk           (clk),
    .resetn        (resetn),
    .pause         (pause),
    .step          (step),
    .breath_step   (breath_step),
    .pwm_phase_nxt (pwm_phase_nxt)
  );

  mode_e               cur_mode,  mode_nxt;
  logic [NUM_LEDS-1:0] cnt,       cnt_nxt;
  logic [POS_W-1:0]    pos,       pos_nxt;
  logic                dir_up,    dir_up_nxt;
  logic [PWM_BITS-1:0] bright,    bright_nxt;
  logic                bright_up, bright_up_nxt;
  logic [NUM_LEDS-1:0] leds_nxt;
  logic                mode_chg;

  // A mode change is only recognised on a step; that step restarts the pattern.
  assign mode_chg = step && (mode_e'(mode) != cur_mode);

  // State register: pattern state, selected mode, and the registered pins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cur_mode  <= MODE_BIN;
      cnt       <= '0;
      pos       <= '0;
      dir_up    <= 1'b1;
      bright    <= '0;
      bright_up <= 1'b1;
      leds      <= '0;
      tick      <= 1'b0;
    end else begin
      cur_mode  <= mode_nxt;
      cnt       <= cnt_nxt;
      pos       <= pos_nxt;
      dir_up    <= dir_up_nxt;
      bright    <= bright_nxt;
      bright_up <= bright_up_nxt;
      leds      <= leds_nxt;
      tick      <= step;
    end
  end

  // Next-state: restart on mode change, otherwise advance the active pattern.
  always_comb begin
    mode_nxt      = cur_mode;
    cnt_nxt       = cnt;
    pos_nxt       = pos;
    dir_up_nxt    = dir_up;
    bright_nxt    = bright;
    bright_up_nxt = bright_up;

    if (step) begin
      mode_nxt = mode_e'(mode);
    end

    if (mode_chg) begin
      cnt_nxt       = '0;
      pos_nxt       = '0;
      dir_up_nxt    = 1'b1;
      bright_nxt    = '0;
      bright_up_nxt = 1'b1;
    end else begin
      if (step && (cur_mode == MODE_BIN || cur_mode == MODE_GRAY)) begin
        cnt_nxt = cnt + NUM_LEDS'(1);
      end

      // Scanner bounces between the end LEDs without dwelling on them.
      if (step && cur_mode == MODE_SCAN) begin
        if (NUM_LEDS == 1) begin
          pos_nxt = '0;
        end else if (dir_up) begin
          if (pos == POS_LAST) begin
            pos_nxt    = pos - POS_W'(1);
            dir_up_nxt = 1'b0;
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end else begin
          if (pos == '0) begin
            pos_nxt    = POS_W'(1);
            dir_up_nxt = 1'b1;
          end else begin
            pos_nxt = pos - POS_W'(1);
          end
        end
      end

      // Brightness ramps as a triangle wave on the faster breath strobe.
      if (breath_step && cur_mode == MODE_BREATHE) begin
        if (bright_up) begin
          if (bright == BRIGHT_MAX) begin
            bright_nxt    = bright - PWM_BITS'(1);
            bright_up_nxt = 1'b0;
          end else begin
            bright_nxt = bright + PWM_BITS'(1);
          end
        end else begin
          if (bright == '0) begin
            bright_nxt    = PWM_BITS'(1);
            bright_up_nxt = 1'b1;
          end else begin
            bright_nxt = bright - PWM_BITS'(1);
          end
        end
      end
    end
  end

  // Output decode from post-update state; a paused cycle holds the pins.
  always_comb begin
    leds_nxt = leds;
    if (!pause) begin
      case (mode_nxt)
        MODE_BIN:     leds_nxt = cnt_nxt;
        MODE_GRAY:    leds_nxt = NUM_LEDS'(bin2gray(32'(cnt_nxt)));
        MODE_SCAN:    leds_nxt = NUM_LEDS'(1) << pos_nxt;
        MODE_BREATHE: leds_nxt = {NUM_LEDS{pwm_phase_nxt < bright_nxt}};
        default:      leds_nxt = leds;
      endcase
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench: directed phases then random mode/pause traffic,
// compared every cycle against a step-count based reference model.
module tb_led_pattern_gen;

  localparam int N      = 5;
  localparam int LD     = 4;
  localparam int BL     = 3;
  localparam int PB     = 2;
  localparam int PERIOD = 1 << LD;
  localparam int BPER   = 1 << BL;
  localparam int BMAX   = (1 << PB) - 1;

  logic         clk    = 1'b0;
  logic         resetn = 1'b0;
  logic         pause  = 1'b0;
  logic [1:0]   mode   = 2'd0;
  logic [N-1:0] leds;
  logic         tick;

  int checks   = 0;
  int failures = 0;
  int tick_cnt = 0;
  string cur_test = "init";

  // Reference model: prescaler value plus "steps taken in this mode" counters.
  int           m_presc;
  int           m_mode;
  int           m_k;
  int           m_b;
  int           m_tick;
  logic [N-1:0] m_leds;

  led_pattern_gen #(
    .NUM_LEDS    (N),
    .LOG2DELAY   (LD),
    .BREATH_LOG2 (BL),
    .PWM_BITS    (PB)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .mode   (mode),
    .pause  (pause),
    .leds   (leds),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s/%s observed=%0h expected=%0h", cur_test, tag, obs, exp);
    end
  endtask

  // Triangle wave 0..top..0 indexed by number of steps taken.
  function automatic int tri_wave(input int k, input int top);
    int p;
    if (top == 0) return 0;
    p = k % (2 * top);
    return (p <= top) ? p : 2 * top - p;
  endfunction

  task automatic model_reset();
    m_presc = 0;
    m_mode  = 0;
    m_k     = 0;
    m_b     = 0;
    m_tick  = 0;
    m_leds  = '0;
  endtask

  task automatic model_edge();
    bit st;
    bit bst;
    int phase;
    int g;
    int b;
    if (!resetn) begin
      model_reset();
      return;
    end
    if (pause) begin
      m_tick = 0;
      return;
    end
    st      = (m_presc == PERIOD - 1);
    bst     = ((m_presc % BPER) == BPER - 1);
    m_presc = (m_presc + 1) % PERIOD;
    m_tick  = st ? 1 : 0;
    if (st && int'(mode) != m_mode) begin
      m_mode = int'(mode);
      m_k    = 0;
      m_b    = 0;
    end else begin
      if (st && m_mode != 3) m_k++;
      if (bst && m_mode == 3) m_b++;
    end
    phase = m_presc % (1 << PB);
    case (m_mode)
      0: m_leds = N'(m_k % (1 << N));
      1: begin
        g      = m_k % (1 << N);
        m_leds = N'(g ^ (g >> 1));
      end
      2: m_leds = N'(1 << tri_wave(m_k, N - 1));
      default: begin
        b      = tri_wave(m_b, BMAX);
        m_leds = (phase < b) ? '1 : '0;
      end
    endcase
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("leds", leds, m_leds);
      chk("tick", tick, m_tick);
      if (tick === 1'b1) tick_cnt++;
      if (m_mode == 2) chk("onehot", $countones(leds), 1);
    end
  endtask

  initial begin
    // Reset state
    cur_test = "reset";
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("leds0", leds, 0);
    chk("tick0", tick, 0);
    resetn = 1'b1;

    // Binary count, first tick 16 cycles after release
    cur_test = "binary";
    tick_cnt = 0;
    cyc(5 * PERIOD);
    chk("ticks", tick_cnt, 5);
    chk("leds_end", leds, 5);

    // Gray count, long enough to wrap the 5-bit counter
    cur_test = "gray";
    mode = 2'd1;
    cyc(34 * PERIOD);

    // Scanner bounce
    cur_test = "scan";
    mode = 2'd2;
    cyc(11 * PERIOD);

    // Breathing triangle and PWM duty
    cur_test = "breathe";
    mode = 2'd3;
    cyc(8 * PERIOD);

    // Pause mid-scan: no ticks, leds frozen, prescaler resumes
    cur_test = "pause";
    mode = 2'd2;
    cyc(3 * PERIOD + 5);
    pause    = 1'b1;
    tick_cnt = 0;
    cyc(40);
    chk("no_tick", tick_cnt, 0);
    pause = 1'b0;
    cyc(2 * PERIOD);

    // Mode switch between steps takes effect only at the next step
    cur_test = "midswitch";
    mode = 2'd0;
    cyc(2 * PERIOD);
    cyc(5);
    mode = 2'd2;
    cyc(PERIOD);

    // Reset mid-period: immediate return to reset values
    cur_test = "midreset";
    cyc(PERIOD / 2 + 3);
    resetn = 1'b0;
    #1;
    chk("leds_async", leds, 0);
    chk("tick_async", tick, 0);
    model_reset();
    cyc(3);
    resetn = 1'b1;
    cyc(2 * PERIOD);

    // Random mode and pause traffic
    cur_test = "random";
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) mode = 2'($urandom_range(0, 3));
      pause = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 40));
    end
    pause = 1'b0;
    cyc(PERIOD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
